// File: rtl/arb_outport_if.sv
// Request/grant bundle between the input-buffer FSMs and one output-port arbiter.
// master = requesters side, slave = arbiter side.
interface arb_outport_if #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2
);
    logic [NUM_PORTS-1:0] req;
    logic                 nfull;
    logic [NUM_PORTS-1:0] ack;
    logic [SEL_W-1:0]     sel;
    logic                 busy;

    modport master (output req, nfull, input ack, sel, busy);
    modport slave  (input req, nfull, output ack, sel, busy);
endinterface

// File: rtl/arb_outport.sv
// Per-output-port packet arbiter: grants one input and holds it from head to tail.
// Define ARB_RR_EN for rotating priority; otherwise fixed priority with input 0 highest.
module arb_outport (
    input  logic          clk,
    input  logic          rst,
    arb_outport_if.slave  port
);
    localparam int NP = 4;
    localparam int SW = 2;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NP-1:0]   ack_q, ack_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [SW-1:0]   start;
    logic [SW-1:0]   idx;
    logic [SW-1:0]   win;
    logic            win_vld;

`ifdef ARB_RR_EN
    logic [SW-1:0]   ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Walk downward in offset so the lowest offset from start wins last.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            idx = start + SW'(i);
            if (port.req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
`ifdef ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (state_q == IDLE) begin
            ack_d  = '0;
            sel_d  = '0;
            busy_d = 1'b0;
            if (!port.nfull && win_vld) begin
                state_d    = HOLD;
                ack_d[win] = 1'b1;
                sel_d      = win;
                busy_d     = 1'b1;
`ifdef ARB_RR_EN
                ptr_d      = win + SW'(1);
`endif
            end
        end else if (!port.req[sel_q]) begin
            // Tail consumed: drop the grant and spend one cycle in IDLE.
            state_d = IDLE;
            ack_d   = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
`ifdef ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign port.ack  = ack_q;
    assign port.sel  = sel_q;
    assign port.busy = busy_q;
endmodule

// File: tb/tb_arb_outport.sv
// Bench for arb_outport: vector table plus hand sequences, expectations queued per cycle.
module tb_arb_outport;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arb_outport_if bus ();
    arb_outport dut (.clk(clk), .rst(rst), .port(bus.slave));

    typedef struct packed {
        logic [3:0] ack;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic       nfull;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic exp_t mk(input logic [3:0] a, input logic [1:0] s, input logic b);
        exp_t e;
        e.ack = a; e.sel = s; e.busy = b;
        return e;
    endfunction

    function automatic void add(input logic [3:0] r, input logic nf, input exp_t e);
        vec_t v;
        v.req = r; v.nfull = nf; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input exp_t e);
        checks++;
        if (bus.ack === e.ack && bus.sel === e.sel && bus.busy === e.busy)
            passed++;
        else
            $display("FAIL %s: got ack=%b sel=%0d busy=%b, want ack=%b sel=%0d busy=%b",
                     nm, bus.ack, bus.sel, bus.busy, e.ack, e.sel, e.busy);
    endtask

    task automatic step(input string nm, input logic [3:0] r, input logic nf, input exp_t e);
        bus.req   = r;
        bus.nfull = nf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check(nm, sb_q.pop_front());
    endtask

    int         gseq [5];
    logic [3:0] oh;
    exp_t       zero;

    initial begin
        zero = mk(4'b0000, 2'd0, 1'b0);
`ifdef ARB_RR_EN
        gseq = '{0, 1, 2, 3, 0};
`else
        gseq = '{0, 0, 0, 0, 0};
`endif
        // Rotation with constant requests; the granted input drops out after 3 grant cycles.
        foreach (gseq[k]) begin
            oh = 4'b0001 << gseq[k];
            add(4'b1111, 1'b0, mk(oh, 2'(gseq[k]), 1'b1));
            add(4'b1111, 1'b0, mk(oh, 2'(gseq[k]), 1'b1));
            add(4'b1111, 1'b0, mk(oh, 2'(gseq[k]), 1'b1));
            add(4'b1111 & ~oh, 1'b0, zero);
        end
        // Single packet on input 2.
        for (int k = 0; k < 5; k++) add(4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1));
        add(4'b0000, 1'b0, zero);
        // Input 1 holds against input 3; handover costs an idle cycle.
        add(4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        add(4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        add(4'b1010, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        add(4'b1010, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        add(4'b1000, 1'b0, zero);
        add(4'b1000, 1'b0, mk(4'b1000, 2'd3, 1'b1));
        add(4'b0000, 1'b0, zero);
        // Backpressure blocks new grants but never breaks a held one.
        add(4'b0001, 1'b1, zero);
        add(4'b0001, 1'b1, zero);
        add(4'b0001, 1'b0, mk(4'b0001, 2'd0, 1'b1));
        add(4'b0001, 1'b1, mk(4'b0001, 2'd0, 1'b1));
        add(4'b0001, 1'b1, mk(4'b0001, 2'd0, 1'b1));
        add(4'b0000, 1'b1, zero);
        add(4'b0100, 1'b1, zero);
        add(4'b0000, 1'b0, zero);
        // Pointer now sits at 1: rotating picks 3, fixed picks 0.
`ifdef ARB_RR_EN
        add(4'b1001, 1'b0, mk(4'b1000, 2'd3, 1'b1));
`else
        add(4'b1001, 1'b0, mk(4'b0001, 2'd0, 1'b1));
`endif
        add(4'b0000, 1'b0, zero);

        rst       = 1'b0;
        bus.req   = 4'b1111;
        bus.nfull = 1'b0;
        #12;
        check("reset_hold", zero);
        #1 rst = 1'b1;

        foreach (vecs[k])
            step($sformatf("vec%0d", k), vecs[k].req, vecs[k].nfull, vecs[k].exp);

        // Async reset mid-packet, between edges; pointer must restart at 0.
        step("async_grant", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        #2 rst = 1'b0;
        #1 check("async_clear", zero);
        #2 rst = 1'b1;
        step("after_reset", 4'b1110, 1'b0, mk(4'b0010, 2'd1, 1'b1));
        step("after_reset_rel", 4'b0000, 1'b0, zero);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
